// File: rtl/spi_reg_bridge_if.sv
// Signal bundle between the SPI slave byte engine / register bus and the bridge.
// The bridge connects through the master modport; the surrounding logic uses slave.
interface spi_reg_bridge_if #(
    parameter int ADDR_W = 7
);
    logic [7:0]        rx_data_i;
    logic              rx_valid_i;
    logic              frame_start_i;
    logic              frame_end_i;
    logic [7:0]        tx_data_o;
    logic              tx_wr_en_o;
    logic              tx_ack_i;
    logic [ADDR_W-1:0] reg_addr_o;
    logic [7:0]        reg_wdata_o;
    logic              reg_we_o;
    logic              reg_re_o;
    logic [7:0]        reg_rdata_i;
    logic              busy_o;
    logic              err_o;

    modport master (
        input  rx_data_i, rx_valid_i, frame_start_i, frame_end_i, tx_ack_i, reg_rdata_i,
        output tx_data_o, tx_wr_en_o, reg_addr_o, reg_wdata_o, reg_we_o, reg_re_o,
               busy_o, err_o
    );

    modport slave (
        output rx_data_i, rx_valid_i, frame_start_i, frame_end_i, tx_ack_i, reg_rdata_i,
        input  tx_data_o, tx_wr_en_o, reg_addr_o, reg_wdata_o, reg_we_o, reg_re_o,
               busy_o, err_o
    );
endinterface

// File: rtl/spi_reg_bridge.sv
// Decodes SPI command frames into auto-incrementing register writes/reads and
// returns read data to the SPI transmitter through a request/acknowledge handshake.
module spi_reg_bridge #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int          ADDR_W    = 7
) (
    input  logic               clk,
    input  logic               rst,
    spi_reg_bridge_if.master   bus
);
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CMD      = 3'd1,
        S_WR_DATA  = 3'd2,
        S_RD_FETCH = 3'd3,
        S_RD_WAIT  = 3'd4,
        S_RD_LOAD  = 3'd5,
        S_RD_NEXT  = 3'd6
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic              rx_valid_q;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_wr_en_q, tx_wr_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              rx_byte_s;

    assign rx_byte_s = bus.rx_valid_i & ~rx_valid_q;

    // State and output registers; every output comes straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_wr_en_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 8'h00;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_valid_q <= bus.rx_valid_i;
            tx_data_q  <= tx_data_d;
            tx_wr_en_q <= tx_wr_en_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            re_q       <= re_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    // Next-state and next-output decode; frame start/end override the per-state result.
    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_wr_en_d = tx_wr_en_q & ~bus.tx_ack_i;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        re_d       = 1'b0;
        err_d      = 1'b0;
        // A write strobe just issued moves the address on for the next data byte.
        if (we_q) begin
            addr_d = addr_q + ADDR_ONE;
        end else begin
            addr_d = addr_q;
        end

        case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
            end
            S_CMD: begin
                if (rx_byte_s) begin
                    addr_d     = bus.rx_data_i[ADDR_W-1:0];
                    tx_wr_en_d = 1'b0;
                    if (bus.rx_data_i[7]) begin
                        re_d    = 1'b1;
                        state_d = S_RD_FETCH;
                    end else begin
                        state_d = S_WR_DATA;
                    end
                end else begin
                    state_d = S_CMD;
                end
            end
            S_WR_DATA: begin
                if (rx_byte_s) begin
                    wdata_d = bus.rx_data_i;
                    we_d    = 1'b1;
                end else begin
                    wdata_d = wdata_q;
                end
            end
            S_RD_FETCH: begin
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                tx_data_d  = bus.reg_rdata_i;
                tx_wr_en_d = 1'b1;
                state_d    = S_RD_LOAD;
            end
            S_RD_LOAD: begin
                if (bus.tx_ack_i) begin
                    tx_wr_en_d = 1'b0;
                    state_d    = S_RD_NEXT;
                end else if (rx_byte_s) begin
                    // Master clocked a byte out before our data was taken: underrun.
                    err_d      = 1'b1;
                    tx_wr_en_d = 1'b0;
                    addr_d     = addr_q + ADDR_ONE;
                    re_d       = 1'b1;
                    state_d    = S_RD_FETCH;
                end else begin
                    state_d = S_RD_LOAD;
                end
            end
            S_RD_NEXT: begin
                if (rx_byte_s) begin
                    addr_d  = addr_q + ADDR_ONE;
                    re_d    = 1'b1;
                    state_d = S_RD_FETCH;
                end else begin
                    state_d = S_RD_NEXT;
                end
            end
            default: begin
                state_d    = S_IDLE;
                tx_wr_en_d = 1'b0;
            end
        endcase

        if (bus.frame_start_i) begin
            tx_data_d  = SYNC_BYTE;
            tx_wr_en_d = 1'b1;
            we_d       = 1'b0;
            re_d       = 1'b0;
            err_d      = 1'b0;
            state_d    = S_CMD;
        end else if (bus.frame_end_i && (state_q != S_IDLE)) begin
            // A write landing together with frame end is kept; reads are abandoned.
            tx_wr_en_d = 1'b0;
            re_d       = 1'b0;
            err_d      = 1'b0;
            state_d    = S_IDLE;
        end else begin
            state_d = state_d;
        end

        busy_d = (state_d != S_IDLE);
    end

    assign bus.tx_data_o   = tx_data_q;
    assign bus.tx_wr_en_o  = tx_wr_en_q;
    assign bus.reg_addr_o  = addr_q;
    assign bus.reg_wdata_o = wdata_q;
    assign bus.reg_we_o    = we_q;
    assign bus.reg_re_o    = re_q;
    assign bus.busy_o      = busy_q;
    assign bus.err_o       = err_q;
endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: transaction queues and a frame-level model
// checked against the DUT every cycle, plus literal spot checks.
module tb_spi_reg_bridge;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_reg_bridge_if #(.ADDR_W(7)) bif ();

    spi_reg_bridge #(.SYNC_BYTE(8'hA5), .ADDR_W(7)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    typedef struct {
        logic [7:0] data;
        int         due;
    } tx_exp_t;

    int         n_checks = 0;
    int         n_errs   = 0;
    int         cyc      = 0;
    bit         chk_on   = 1'b0;
    bit         ack_en   = 1'b0;
    bit         model_busy = 1'b0;
    logic       prev_wr  = 1'b0;
    logic [7:0] prev_tx  = 8'h00;
    int         err_pulses = 0;
    logic [14:0] exp_wr[$];
    logic [6:0]  exp_rd[$];
    tx_exp_t     exp_tx[$];
    logic [7:0]  tx_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter: acknowledges a pending load one cycle after seeing it.
    always @(posedge clk) bif.tx_ack_i <= ack_en && bif.tx_wr_en_o && !bif.tx_ack_i;

    // Register file: read data is addr + 8'h40, valid only in the cycle after the strobe.
    always @(posedge clk) bif.reg_rdata_i <= bif.reg_re_o ? ({1'b0, bif.reg_addr_o} + 8'h40) : 8'hEE;

    // Compare process: checks DUT outputs, then advances the model from the driven inputs.
    always @(negedge clk) begin
        if (chk_on) begin
            tx_exp_t e;
            logic [14:0] w;
            logic [6:0]  a;
            chk("busy", bif.busy_o, model_busy);
            chk("we_re_exclusive", bif.reg_we_o & bif.reg_re_o, 0);
            if (bif.reg_we_o) begin
                chk("write_expected", exp_wr.size() > 0, 1);
                if (exp_wr.size() > 0) begin
                    w = exp_wr.pop_front();
                    chk("write_addr_data", {bif.reg_addr_o, bif.reg_wdata_o}, w);
                end
            end
            if (bif.reg_re_o) begin
                chk("read_expected", exp_rd.size() > 0, 1);
                if (exp_rd.size() > 0) begin
                    a = exp_rd.pop_front();
                    chk("read_addr", bif.reg_addr_o, a);
                    exp_tx.push_back('{data: {1'b0, a} + 8'h40, due: cyc + 2});
                end
            end
            if (bif.tx_wr_en_o && !prev_wr) begin
                tx_log.push_back(bif.tx_data_o);
                chk("tx_load_expected", exp_tx.size() > 0, 1);
                if (exp_tx.size() > 0) begin
                    e = exp_tx.pop_front();
                    chk("tx_data", bif.tx_data_o, e.data);
                    chk("tx_latency", cyc, e.due);
                end
            end
            if (bif.tx_wr_en_o && prev_wr) begin
                chk("tx_stable", bif.tx_data_o, prev_tx);
            end
            if (bif.err_o) err_pulses++;
            if (!rst && bif.frame_start_i) exp_tx.push_back('{data: 8'hA5, due: cyc + 1});
            if (rst) model_busy = 1'b0;
            else if (bif.frame_start_i) model_busy = 1'b1;
            else if (bif.frame_end_i) model_busy = 1'b0;
            prev_wr = bif.tx_wr_en_o;
            prev_tx = bif.tx_data_o;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic fstart();
        bif.frame_start_i = 1'b1;
        tick(1);
        bif.frame_start_i = 1'b0;
        tick(5);
    endtask

    task automatic fend();
        bif.frame_end_i = 1'b1;
        tick(1);
        bif.frame_end_i = 1'b0;
        tick(3);
    endtask

    task automatic sbyte(input logic [7:0] b, input bit fe);
        bif.rx_data_i   = b;
        bif.rx_valid_i  = 1'b1;
        bif.frame_end_i = fe;
        tick(1);
        bif.rx_valid_i  = 1'b0;
        bif.frame_end_i = 1'b0;
        tick(7);
    endtask

    initial begin
        rst               = 1'b1;
        bif.rx_data_i     = 8'h00;
        bif.rx_valid_i    = 1'b0;
        bif.frame_start_i = 1'b0;
        bif.frame_end_i   = 1'b0;
        @(posedge clk);
        #1;
        chk_on = 1'b1;

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            bif.rx_data_i     = 8'($urandom);
            bif.rx_valid_i    = 1'($urandom_range(0, 1));
            bif.frame_start_i = 1'($urandom_range(0, 1));
            bif.frame_end_i   = 1'($urandom_range(0, 1));
            tick(1);
        end
        chk("rst_tx_data", bif.tx_data_o, 8'h00);
        chk("rst_tx_wr_en", bif.tx_wr_en_o, 0);
        chk("rst_addr", bif.reg_addr_o, 7'h00);
        chk("rst_wdata", bif.reg_wdata_o, 8'h00);
        chk("rst_we_re_err", {bif.reg_we_o, bif.reg_re_o, bif.err_o}, 3'b000);
        chk("rst_busy", bif.busy_o, 0);
        bif.rx_valid_i    = 1'b0;
        bif.frame_start_i = 1'b0;
        bif.frame_end_i   = 1'b0;
        tick(1);
        rst    = 1'b0;
        ack_en = 1'b1;
        tick(2);

        // Sync byte offered at frame start, then write burst 10/11, 11/22, 12/33
        exp_wr.push_back({7'h10, 8'h11});
        exp_wr.push_back({7'h11, 8'h22});
        exp_wr.push_back({7'h12, 8'h33});
        bif.frame_start_i = 1'b1;
        tick(1);
        bif.frame_start_i = 1'b0;
        chk("sync_data", bif.tx_data_o, 8'hA5);
        chk("sync_wr_en", bif.tx_wr_en_o, 1);
        tick(5);
        chk("sync_acked", bif.tx_wr_en_o, 0);
        sbyte(8'h10, 1'b0);
        sbyte(8'h11, 1'b0);
        sbyte(8'h22, 1'b0);
        sbyte(8'h33, 1'b0);
        chk("wr_busy_in_frame", bif.busy_o, 1);
        fend();
        chk("wr_busy_after_end", bif.busy_o, 0);

        // Read burst from 05
        exp_rd.push_back(7'h05);
        exp_rd.push_back(7'h06);
        exp_rd.push_back(7'h07);
        fstart();
        tx_log.delete();
        sbyte(8'h85, 1'b0);
        sbyte(8'h00, 1'b0);
        sbyte(8'h00, 1'b0);
        fend();
        chk("rd_load_count", tx_log.size(), 3);
        if (tx_log.size() == 3) begin
            chk("rd_load0", tx_log[0], 8'h45);
            chk("rd_load1", tx_log[1], 8'h46);
            chk("rd_load2", tx_log[2], 8'h47);
        end

        // Address wrap 7E, 7F, 00
        exp_wr.push_back({7'h7E, 8'hAA});
        exp_wr.push_back({7'h7F, 8'hBB});
        exp_wr.push_back({7'h00, 8'hCC});
        fstart();
        sbyte(8'h7E, 1'b0);
        sbyte(8'hAA, 1'b0);
        sbyte(8'hBB, 1'b0);
        sbyte(8'hCC, 1'b0);
        fend();

        // Underrun: no ack before the next byte
        exp_rd.push_back(7'h00);
        exp_rd.push_back(7'h01);
        fstart();
        ack_en = 1'b0;
        sbyte(8'h80, 1'b0);
        chk("ur_pending", {bif.tx_wr_en_o, bif.tx_data_o}, {1'b1, 8'h40});
        sbyte(8'h00, 1'b0);
        chk("ur_reload", {bif.tx_wr_en_o, bif.tx_data_o}, {1'b1, 8'h41});
        ack_en = 1'b1;
        tick(4);
        fend();
        chk("ur_err_pulses", err_pulses, 1);

        // Frame end together with the second write byte
        exp_wr.push_back({7'h30, 8'hAA});
        exp_wr.push_back({7'h31, 8'hBB});
        fstart();
        sbyte(8'h30, 1'b0);
        sbyte(8'hAA, 1'b0);
        sbyte(8'hBB, 1'b1);
        chk("end_with_write_idle", bif.busy_o, 0);

        // Frame end while a read load is pending
        exp_rd.push_back(7'h20);
        fstart();
        ack_en = 1'b0;
        sbyte(8'hA0, 1'b0);
        chk("mid_rd_pending", {bif.tx_wr_en_o, bif.tx_data_o}, {1'b1, 8'h60});
        bif.frame_end_i = 1'b1;
        tick(1);
        bif.frame_end_i = 1'b0;
        chk("mid_rd_drop", {bif.tx_wr_en_o, bif.busy_o}, 2'b00);
        ack_en = 1'b1;
        tick(3);

        // Reset in the middle of a write frame
        exp_wr.push_back({7'h50, 8'h01});
        fstart();
        sbyte(8'h50, 1'b0);
        sbyte(8'h01, 1'b0);
        rst            = 1'b1;
        bif.rx_data_i  = 8'h02;
        bif.rx_valid_i = 1'b1;
        tick(1);
        bif.rx_valid_i = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(2);
        chk("mid_rst_addr", bif.reg_addr_o, 7'h00);
        sbyte(8'h03, 1'b0);
        chk("mid_rst_idle", bif.busy_o, 0);

        tick(5);
        chk("writes_drained", exp_wr.size(), 0);
        chk("reads_drained", exp_rd.size(), 0);
        chk("loads_drained", exp_tx.size(), 0);
        chk("total_err_pulses", err_pulses, 1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
